mul_scan_ctrl: RTL

- Byte-stream controller for the instruction-scan datapath.
- Consumes a corrupted-memory character stream and parses `mul(A,B)` instructions.
- Tracks the `do()` / `don't()` enable state with two phrase matchers and sequences a registered multiply-accumulate.
- Sits between the file-reader byte source and the result/report logic; one stream in, one running sum out.

---
 rtl/mul_scan_pkg.sv | 33 +++
 rtl/mul_scan_ctrl_if.sv | 25 ++
 rtl/mul_scan_ctrl_phrase_match.sv | 67 ++++++
 rtl/mul_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mul_scan_pkg.sv
// Shared types, ASCII constants and phrase tables for the mul() instruction scanner.
package mul_scan_pkg;

   typedef enum logic [2:0] {
      ST_SCAN  = 3'd0,
      ST_M     = 3'd1,
      ST_MU    = 3'd2,
      ST_MUL   = 3'd3,
      ST_NUM_A = 3'd4,
      ST_NUM_B = 3'd5,
      ST_MULT  = 3'd6
   } state_e;

   localparam logic [7:0] CH_M     = 8'h6D;
   localparam logic [7:0] CH_U     = 8'h75;
   localparam logic [7:0] CH_L     = 8'h6C;
   localparam logic [7:0] CH_LP    = 8'h28;
   localparam logic [7:0] CH_RP    = 8'h29;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_NINE  = 8'h39;

   localparam int PH_DO_LEN   = 4;
   localparam int PH_DONT_LEN = 7;
   // First character of each phrase sits in the most significant byte.
   localparam logic [8*PH_DO_LEN-1:0]   PH_DO   = "do()";
   localparam logic [8*PH_DONT_LEN-1:0] PH_DONT = "don't()";

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_ZERO) && (c <= CH_NINE);
   endfunction

endpackage

// File: rtl/mul_scan_ctrl_if.sv
// Byte-stream input handshake plus result/status outputs of mul_scan_ctrl.
interface mul_scan_ctrl_if #(
   parameter int SUM_W = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_last;
   logic [SUM_W-1:0] sum_out;
   logic [CNT_W-1:0] mul_count;
   logic             enabled;
   logic             busy;
   logic             done;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, sum_out, mul_count, enabled, busy, done
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, sum_out, mul_count, enabled, busy, done
   );
endinterface

// File: rtl/mul_scan_ctrl_phrase_match.sv
// Sequential matcher for a fixed byte phrase; pulses hit_o the cycle after the last byte matches.
module phrase_match
   import mul_scan_pkg::*;
#(
   parameter int                LEN    = PH_DO_LEN,
   parameter logic [8*LEN-1:0]  PHRASE = PH_DO
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       clr_i,
   input  logic [7:0] byte_i,
   output logic       hit_o
);
   localparam int IDX_W = $clog2(LEN);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             hit_q, hit_d;
   logic [7:0]       ch_s [2**IDX_W];

   // Unused table slots are padded so the index can never select past the phrase.
   for (genvar g = 0; g < 2**IDX_W; g++) begin : g_ch
      if (g < LEN) begin : g_used
         assign ch_s[g] = PHRASE[8*(LEN-1-g) +: 8];
      end else begin : g_pad
         assign ch_s[g] = 8'h00;
      end
   end

   // Next index and hit from the accepted byte.
   always_comb begin
      idx_d = idx_q;
      hit_d = 1'b0;
      if (clr_i) begin
         idx_d = '0;
      end else if (en_i) begin
         if (byte_i == ch_s[idx_q]) begin
            if (idx_q == IDX_W'(LEN-1)) begin
               idx_d = '0;
               hit_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else if (byte_i == ch_s[0]) begin
            idx_d = IDX_W'(1);
         end else begin
            idx_d = '0;
         end
      end else begin
         idx_d = idx_q;
      end
   end

   // Match index and hit registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         hit_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         hit_q <= hit_d;
      end
   end

   assign hit_o = hit_q;

endmodule

// File: rtl/mul_scan_ctrl.sv
// Parses mul(A,B) from a byte stream and accumulates A*B; do()/don't() gating is built
// only when MUL_SCAN_DO_DONT_EN is defined, otherwise every well-formed mul counts.
module mul_scan_ctrl
   import mul_scan_pkg::*;
#(
   parameter int SUM_W      = 32,
   parameter int NUM_W      = 10,
   parameter int MAX_DIGITS = 3,
   parameter int CNT_W      = 16
) (
   input  logic           clk,
   input  logic           rst,
   mul_scan_ctrl_if.slave bus
);
   localparam int              DC_W   = $clog2(MAX_DIGITS + 1);
   localparam int              PROD_W = 2 * NUM_W;
   localparam logic [DC_W-1:0] MAX_DC = DC_W'(MAX_DIGITS);

   state_e             state_q, state_d, abort_s;
   logic [NUM_W-1:0]   a_q, a_d, b_q, b_d, dig_s;
   logic [DC_W-1:0]    cnt_q, cnt_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PROD_W-1:0]  prod_s;
   logic               enabled_q, enabled_d, busy_q, busy_d, done_q, done_d;
   logic               pend_q, pend_d, ready_q;
   logic               accept_s, digit_s, hit_do_s, hit_dont_s;

   assign accept_s = bus.in_valid && ready_q;
   assign digit_s  = is_digit(bus.in_data);
   assign dig_s    = NUM_W'(bus.in_data[3:0]);
   assign prod_s   = PROD_W'(a_q) * PROD_W'(b_q);
   assign abort_s  = (bus.in_data == CH_M) ? ST_M : ST_SCAN;

`ifdef MUL_SCAN_DO_DONT_EN
   phrase_match #(.LEN(PH_DO_LEN), .PHRASE(PH_DO)) u_do (
      .clk(clk), .rst(rst), .en_i(accept_s), .clr_i(accept_s && bus.in_last),
      .byte_i(bus.in_data), .hit_o(hit_do_s)
   );
   phrase_match #(.LEN(PH_DONT_LEN), .PHRASE(PH_DONT)) u_dont (
      .clk(clk), .rst(rst), .en_i(accept_s), .clr_i(accept_s && bus.in_last),
      .byte_i(bus.in_data), .hit_o(hit_dont_s)
   );
`else
   assign hit_do_s   = 1'b0;
   assign hit_dont_s = 1'b0;
`endif

   // Parser next state, operand build-up, accumulation and stream bookkeeping.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      count_d   = count_q;
      busy_d    = busy_q;
      pend_d    = pend_q;
      done_d    = 1'b0;
      enabled_d = enabled_q;

      if (hit_do_s) begin
         enabled_d = 1'b1;
      end else if (hit_dont_s) begin
         enabled_d = 1'b0;
      end else begin
         enabled_d = enabled_q;
      end

      if (state_q == ST_MULT) begin
         if (enabled_q) begin
            sum_d   = sum_q + SUM_W'(prod_s);
            count_d = count_q + CNT_W'(1);
         end else begin
            sum_d   = sum_q;
         end
         state_d = ST_SCAN;
         // A ')' that also carried in_last finishes the stream only after its product lands.
         if (pend_q) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            enabled_d = 1'b1;
            pend_d    = 1'b0;
         end else begin
            pend_d    = 1'b0;
         end
      end else if (accept_s) begin
         if (!busy_q) begin
            sum_d   = '0;
            count_d = '0;
         end else begin
            sum_d   = sum_q;
         end
         busy_d = 1'b1;
         case (state_q)
            ST_SCAN: state_d = (bus.in_data == CH_M) ? ST_M : ST_SCAN;
            ST_M:    state_d = (bus.in_data == CH_U) ? ST_MU : abort_s;
            ST_MU:   state_d = (bus.in_data == CH_L) ? ST_MUL : abort_s;
            ST_MUL: begin
               if (bus.in_data == CH_LP) begin
                  state_d = ST_NUM_A;
                  a_d     = '0;
                  b_d     = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = abort_s;
               end
            end
            ST_NUM_A: begin
               if (digit_s && (cnt_q < MAX_DC)) begin
                  a_d   = a_q * NUM_W'(4'd10) + dig_s;
                  cnt_d = cnt_q + DC_W'(1);
               end else if ((bus.in_data == CH_COMMA) && (cnt_q != '0)) begin
                  state_d = ST_NUM_B;
                  cnt_d   = '0;
               end else begin
                  state_d = abort_s;
               end
            end
            ST_NUM_B: begin
               if (digit_s && (cnt_q < MAX_DC)) begin
                  b_d   = b_q * NUM_W'(4'd10) + dig_s;
                  cnt_d = cnt_q + DC_W'(1);
               end else if ((bus.in_data == CH_RP) && (cnt_q != '0)) begin
                  state_d = ST_MULT;
               end else begin
                  state_d = abort_s;
               end
            end
            default: state_d = ST_SCAN;
         endcase
         if (bus.in_last) begin
            if (state_d == ST_MULT) begin
               pend_d = 1'b1;
            end else begin
               state_d   = ST_SCAN;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               enabled_d = 1'b1;
            end
         end else begin
            pend_d = pend_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_SCAN;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         sum_q     <= '0;
         count_q   <= '0;
         enabled_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pend_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         enabled_q <= enabled_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pend_q    <= pend_d;
         ready_q   <= (state_d != ST_MULT);
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.sum_out   = sum_q;
   assign bus.mul_count = count_q;
   assign bus.enabled   = enabled_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
